// File: rtl/vector_writeback_arbiter_pkg.sv
// Shared types for the vector writeback path: word and register-index types,
// grant encoding and the register one-hot helper used by the pending bitmap.
package vector_writeback_arbiter_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_W      = 5;
  localparam int NUM_REGS   = 32;
  localparam int FIFO_DEPTH = 2;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [REG_W-1:0]    regbits_t;
  typedef logic [NUM_REGS-1:0] regmask_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  function automatic regmask_t reg_onehot(input regbits_t r);
    regmask_t m;
    m = {NUM_REGS{1'b0}};
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/vector_writeback_arbiter_if.sv
// Source-side push channels and register-file write port of the writeback arbiter.
interface vector_writeback_arbiter_if #(
  parameter int THREADS = 4
) ();

  logic                                             alu_valid;
  logic                                             alu_ready;
  vector_writeback_arbiter_pkg::regbits_t           alu_wsel;
  logic [THREADS-1:0]                               alu_mask;
  vector_writeback_arbiter_pkg::word_t [THREADS-1:0] alu_wdata;

  logic                                             mem_valid;
  logic                                             mem_ready;
  vector_writeback_arbiter_pkg::regbits_t           mem_wsel;
  logic [THREADS-1:0]                               mem_mask;
  vector_writeback_arbiter_pkg::word_t [THREADS-1:0] mem_wdata;

  vector_writeback_arbiter_pkg::regbits_t           wsel;
  logic [THREADS-1:0]                               wen;
  vector_writeback_arbiter_pkg::word_t [THREADS-1:0] wdata;
  vector_writeback_arbiter_pkg::regmask_t           pending;

  modport master (
    output alu_valid, alu_wsel, alu_mask, alu_wdata,
    output mem_valid, mem_wsel, mem_mask, mem_wdata,
    input  alu_ready, mem_ready, wsel, wen, wdata, pending
  );

  modport slave (
    input  alu_valid, alu_wsel, alu_mask, alu_wdata,
    input  mem_valid, mem_wsel, mem_mask, mem_wdata,
    output alu_ready, mem_ready, wsel, wen, wdata, pending
  );

endinterface

// File: rtl/vector_writeback_arbiter_wb_fifo.sv
// Two-entry FIFO of packed writeback entries; the register index sits in the top
// REG_W bits of each entry and is tapped per slot for the pending bitmap.
module vector_writeback_arbiter_wb_fifo
  import vector_writeback_arbiter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [W-1:0]                   data_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [W-1:0]                   head_o,
  output logic [FIFO_DEPTH-1:0]          ent_valid_o,
  output regbits_t [FIFO_DEPTH-1:0]      ent_wsel_o
);

  logic [W-1:0] slot_q [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Pointer and occupancy update; callers never push when full or pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        wr_ptr_d = ~wr_ptr_q;
        count_d  = count_q + 2'd1;
      end
      2'b01: begin
        rd_ptr_d = ~rd_ptr_q;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        wr_ptr_d = ~wr_ptr_q;
        rd_ptr_d = ~rd_ptr_q;
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) slot_q[i] <= {W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) slot_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = slot_q[rd_ptr_q];

  // With one entry only the read slot is live; with two both are.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      ent_valid_o[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)));
      ent_wsel_o[i]  = slot_q[i][W-1 -: REG_W];
    end
  end

endmodule

// File: rtl/vector_writeback_arbiter.sv
// Round-robin merge of ALU and memory-unit results onto the single vector
// register-file write port, with a pending-register bitmap for decode hazards.
module vector_writeback_arbiter
  import vector_writeback_arbiter_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic                        clk,
  input  logic                        RST,
  vector_writeback_arbiter_if.slave   bus
);

  typedef struct packed {
    regbits_t                 wsel;
    logic [THREADS-1:0]       mask;
    word_t [THREADS-1:0]      wdata;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  wb_entry_t alu_in_s, mem_in_s, alu_head_s, mem_head_s, sel_s;
  logic      alu_full_s, alu_empty_s, alu_push_s, alu_pop_s;
  logic      mem_full_s, mem_empty_s, mem_push_s, mem_pop_s;
  logic [FIFO_DEPTH-1:0]     alu_vld_s, mem_vld_s;
  regbits_t [FIFO_DEPTH-1:0] alu_ew_s, mem_ew_s;

  grant_e              last_grant_q, last_grant_d, grant_src_s;
  logic                grant_s;
  regbits_t            wsel_q, wsel_d;
  logic [THREADS-1:0]  wen_q, wen_d;
  word_t [THREADS-1:0] wdata_q, wdata_d;
  regmask_t            pending_s;

  assign alu_in_s   = {bus.alu_wsel, bus.alu_mask, bus.alu_wdata};
  assign mem_in_s   = {bus.mem_wsel, bus.mem_mask, bus.mem_wdata};
  assign alu_push_s = bus.alu_valid & ~alu_full_s;
  assign mem_push_s = bus.mem_valid & ~mem_full_s;

  vector_writeback_arbiter_wb_fifo #(.W(ENTRY_W)) u_alu_fifo (
    .clk(clk), .rst(RST), .push_i(alu_push_s), .pop_i(alu_pop_s), .data_i(alu_in_s),
    .full_o(alu_full_s), .empty_o(alu_empty_s), .head_o(alu_head_s),
    .ent_valid_o(alu_vld_s), .ent_wsel_o(alu_ew_s)
  );

  vector_writeback_arbiter_wb_fifo #(.W(ENTRY_W)) u_mem_fifo (
    .clk(clk), .rst(RST), .push_i(mem_push_s), .pop_i(mem_pop_s), .data_i(mem_in_s),
    .full_o(mem_full_s), .empty_o(mem_empty_s), .head_o(mem_head_s),
    .ent_valid_o(mem_vld_s), .ent_wsel_o(mem_ew_s)
  );

  // Arbitration and next write; register 0 and all-zero masks consume a grant without writing.
  always_comb begin
    grant_s     = 1'b0;
    grant_src_s = GRANT_ALU;
    case ({~alu_empty_s, ~mem_empty_s})
      2'b11: begin
        grant_s     = 1'b1;
        grant_src_s = (last_grant_q == GRANT_MEM) ? GRANT_ALU : GRANT_MEM;
      end
      2'b10: begin
        grant_s     = 1'b1;
        grant_src_s = GRANT_ALU;
      end
      2'b01: begin
        grant_s     = 1'b1;
        grant_src_s = GRANT_MEM;
      end
      default: grant_s = 1'b0;
    endcase

    alu_pop_s    = grant_s && (grant_src_s == GRANT_ALU);
    mem_pop_s    = grant_s && (grant_src_s == GRANT_MEM);
    sel_s        = (grant_src_s == GRANT_ALU) ? alu_head_s : mem_head_s;
    last_grant_d = last_grant_q;
    wsel_d       = wsel_q;
    wdata_d      = wdata_q;
    wen_d        = {THREADS{1'b0}};
    if (grant_s) begin
      last_grant_d = grant_src_s;
      wsel_d       = sel_s.wsel;
      wdata_d      = sel_s.wdata;
      wen_d        = (sel_s.wsel == 5'd0) ? {THREADS{1'b0}} : sel_s.mask;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      last_grant_q <= GRANT_MEM;
      wsel_q       <= {REG_W{1'b0}};
      wen_q        <= {THREADS{1'b0}};
      wdata_q      <= {(THREADS*WORD_W){1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      wsel_q       <= wsel_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
    end
  end

  // Every queued entry plus an in-flight write marks its destination busy.
  always_comb begin
    pending_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pending_s = pending_s | (reg_onehot(alu_ew_s[i]) & {NUM_REGS{alu_vld_s[i]}});
      pending_s = pending_s | (reg_onehot(mem_ew_s[i]) & {NUM_REGS{mem_vld_s[i]}});
    end
    pending_s    = pending_s | (reg_onehot(wsel_q) & {NUM_REGS{|wen_q}});
    pending_s[0] = 1'b0;
  end

  assign bus.alu_ready = ~alu_full_s;
  assign bus.mem_ready = ~mem_full_s;
  assign bus.wsel      = wsel_q;
  assign bus.wen       = wen_q;
  assign bus.wdata     = wdata_q;
  assign bus.pending   = pending_s;

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Directed bench for vector_writeback_arbiter: a queue-based reference model is
// compared against the DUT on every negedge, plus hand-computed spot checks.
module tb_vector_writeback_arbiter;
  import vector_writeback_arbiter_pkg::*;

  localparam int T = 4;

  typedef struct packed {
    regbits_t            wsel;
    logic [T-1:0]        mask;
    word_t [T-1:0]       wdata;
  } ent_t;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  vector_writeback_arbiter_if #(.THREADS(T)) bus ();
  vector_writeback_arbiter #(.THREADS(T)) dut (.clk(clk), .RST(RST), .bus(bus));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  regbits_t    wlog[$];
  ent_t        aq[$];
  ent_t        mq[$];
  logic        last_mem = 1'b1;
  logic [T-1:0] e_wen   = '0;
  regbits_t    e_wsel   = '0;
  word_t [T-1:0] e_wdata = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_alu(input logic v, input regbits_t w, input logic [T-1:0] m, input int base);
    bus.alu_valid = v;
    bus.alu_wsel  = w;
    bus.alu_mask  = m;
    for (int t = 0; t < T; t++) bus.alu_wdata[t] = word_t'(base + t);
  endtask

  task automatic drive_mem(input logic v, input regbits_t w, input logic [T-1:0] m, input int base);
    bus.mem_valid = v;
    bus.mem_wsel  = w;
    bus.mem_mask  = m;
    for (int t = 0; t < T; t++) bus.mem_wdata[t] = word_t'(base + t);
  endtask

  task automatic idle();
    drive_alu(1'b0, 5'd0, 4'b0000, 0);
    drive_mem(1'b0, 5'd0, 4'b0000, 0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-source queues, round-robin favouring the source not served last.
  always @(posedge clk or posedge RST) begin : model
    ent_t g;
    logic acc_a, acc_m, take_m;
    if (RST) begin
      aq.delete();
      mq.delete();
      last_mem = 1'b1;
      e_wen    = '0;
      e_wsel   = '0;
      e_wdata  = '0;
    end else begin
      acc_a = bus.alu_valid && (aq.size() < 2);
      acc_m = bus.mem_valid && (mq.size() < 2);
      if (aq.size() > 0 || mq.size() > 0) begin
        take_m = (mq.size() > 0) && ((aq.size() == 0) || !last_mem);
        if (take_m) g = mq.pop_front();
        else        g = aq.pop_front();
        last_mem = take_m;
        e_wsel   = g.wsel;
        e_wdata  = g.wdata;
        e_wen    = (g.wsel == 5'd0) ? 4'b0000 : g.mask;
      end else begin
        e_wen = '0;
      end
      if (acc_a) aq.push_back({bus.alu_wsel, bus.alu_mask, bus.alu_wdata});
      if (acc_m) mq.push_back({bus.mem_wsel, bus.mem_mask, bus.mem_wdata});
    end
  end

  always @(negedge clk) begin : compare
    regmask_t ep;
    if (!RST) begin
      ep = '0;
      foreach (aq[i]) ep[aq[i].wsel] = 1'b1;
      foreach (mq[i]) ep[mq[i].wsel] = 1'b1;
      if (e_wen != '0) ep[e_wsel] = 1'b1;
      ep[0] = 1'b0;
      check("alu_ready", bus.alu_ready, aq.size() < 2);
      check("mem_ready", bus.mem_ready, mq.size() < 2);
      check("wen", bus.wen, e_wen);
      check("wsel", bus.wsel, e_wsel);
      check("wdata", bus.wdata, e_wdata);
      check("pending", bus.pending, ep);
      if (bus.wen != '0) begin
        wr_count++;
        wlog.push_back(bus.wsel);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ia, im, guard, base_wr;
    logic ra, rm, saw_a_low, saw_m_low;
    int hold_seq[5];
    hold_seq = '{10, 3, 11, 4, 12};

    idle();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    check("rst_wen", bus.wen, 4'b0000);
    check("rst_wsel", bus.wsel, 5'd0);
    check("rst_wdata", bus.wdata, 128'd0);
    check("rst_pending", bus.pending, 32'd0);
    check("rst_alu_ready", bus.alu_ready, 1'b1);
    check("rst_mem_ready", bus.mem_ready, 1'b1);
    nxt();

    // Single ALU push: wen in cycle 2, pending[5] in cycles 1-2 only.
    drive_alu(1'b1, 5'd5, 4'b1011, 1);
    nxt();
    idle();
    @(negedge clk);
    check("single_pend_c1", bus.pending[5], 1'b1);
    check("single_wen_c1", bus.wen, 4'b0000);
    nxt();
    @(negedge clk);
    check("single_wen_c2", bus.wen, 4'b1011);
    check("single_wsel_c2", bus.wsel, 5'd5);
    check("single_wdata_c2", bus.wdata, {32'd4, 32'd3, 32'd2, 32'd1});
    check("single_pend_c2", bus.pending[5], 1'b1);
    nxt();
    @(negedge clk);
    check("single_pend_c3", bus.pending[5], 1'b0);
    check("single_wen_c3", bus.wen, 4'b0000);
    nxt();

    // Full ALU FIFO while MEM wins: the offered wsel 9 must never be taken.
    wlog.delete();
    drive_alu(1'b1, 5'd3, 4'b1111, 48);
    drive_mem(1'b1, 5'd10, 4'b1111, 100);
    nxt();
    drive_alu(1'b1, 5'd4, 4'b1111, 52);
    drive_mem(1'b1, 5'd11, 4'b1111, 104);
    nxt();
    drive_alu(1'b1, 5'd9, 4'b1111, 90);
    drive_mem(1'b1, 5'd12, 4'b1111, 108);
    @(negedge clk);
    check("hold_alu_ready", bus.alu_ready, 1'b0);
    nxt();
    idle();
    repeat (6) nxt();
    check("hold_count", wlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) check("hold_order", wlog[i], hold_seq[i]);

    // Reset in the middle of traffic.
    for (int k = 0; k < 3; k++) begin
      drive_alu(1'b1, 5'd20, 4'b1111, 300 + k * 4);
      drive_mem(1'b1, 5'd21, 4'b1111, 350 + k * 4);
      nxt();
    end
    #2 RST = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    check("mrst_wen", bus.wen, 4'b0000);
    check("mrst_pending", bus.pending, 32'd0);
    check("mrst_alu_ready", bus.alu_ready, 1'b1);
    check("mrst_mem_ready", bus.mem_ready, 1'b1);
    base_wr = wr_count;
    repeat (5) nxt();
    check("mrst_no_stale", wr_count, base_wr);

    // Contention: 8 entries each, ALU first after reset, strict alternation.
    wlog.delete();
    base_wr   = wr_count;
    ia        = 0;
    im        = 0;
    guard     = 0;
    saw_a_low = 1'b0;
    saw_m_low = 1'b0;
    while ((ia < 8 || im < 8) && guard < 60) begin
      drive_alu(ia < 8, 5'd1, 4'b1111, 200 + ia * 4);
      drive_mem(im < 8, 5'd2, 4'b0111, 400 + im * 4);
      @(negedge clk);
      ra = bus.alu_ready;
      rm = bus.mem_ready;
      if (!ra) saw_a_low = 1'b1;
      if (!rm) saw_m_low = 1'b1;
      nxt();
      if (ra && ia < 8) ia++;
      if (rm && im < 8) im++;
      guard++;
    end
    check("cont_sent", ia + im, 16);
    idle();
    repeat (8) nxt();
    check("cont_writes", wr_count - base_wr, 16);
    check("cont_log_size", wlog.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < wlog.size()) check("cont_alternate", wlog[i], (i % 2 == 0) ? 5'd1 : 5'd2);
    check("cont_alu_ready_dropped", saw_a_low, 1'b1);
    check("cont_mem_ready_dropped", saw_m_low, 1'b1);

    // Register 0: consumed, never written, never pending.
    base_wr = wr_count;
    drive_mem(1'b1, 5'd0, 4'b1111, 500);
    nxt();
    idle();
    @(negedge clk);
    check("r0_pending_c1", bus.pending, 32'd0);
    nxt();
    @(negedge clk);
    check("r0_wen_c2", bus.wen, 4'b0000);
    check("r0_pending_c2", bus.pending, 32'd0);
    nxt();
    check("r0_no_write", wr_count, base_wr);

    // Zero mask followed immediately by a real write.
    drive_alu(1'b1, 5'd7, 4'b0000, 600);
    nxt();
    drive_alu(1'b1, 5'd8, 4'b1111, 700);
    @(negedge clk);
    check("zm_pend7_c1", bus.pending[7], 1'b1);
    nxt();
    idle();
    @(negedge clk);
    check("zm_wen_c2", bus.wen, 4'b0000);
    check("zm_wsel_c2", bus.wsel, 5'd7);
    nxt();
    @(negedge clk);
    check("zm_wen_c3", bus.wen, 4'b1111);
    check("zm_wsel_c3", bus.wsel, 5'd8);
    repeat (3) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_writeback_arbiter.md
# vector_writeback_arbiter

Merges per-thread results from the vector ALU and the vector memory unit onto the single write port of the vector register file. Each source pushes into its own 2-entry FIFO. A round-robin arbiter selects one head entry per cycle and drives a registered write (wsel, per-thread wen, per-thread wdata) into the register file. A pending-register bitmap is exported for decode-stage hazard checks.

## Interface
Parameters:
- THREADS, 4, number of SIMT lanes; width of every mask and data vector.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU FIFO can accept; equals ALU FIFO count < 2.
- alu_wsel  in  5  destination register.
- alu_mask  in  THREADS  per-thread write enable.
- alu_wdata  in  THREADS x word_t  per-thread result.
- mem_valid, mem_ready, mem_wsel, mem_mask, mem_wdata  same as the ALU ports, for the memory unit.
- wsel  out  5  register file write select.
- wen  out  THREADS  per-thread write enable; high for one cycle per granted entry.
- wdata  out  THREADS x word_t  per-thread write data.
- pending  out  32  bit r set while any write to register r sits in either FIFO or the output register.

## Operation
- Push: a source pushes when valid && ready. A push into a full FIFO is impossible because ready is low. When full, a push and a pop in the same cycle are not merged; ready stays low that cycle.
- Arbitration uses a one-bit last_grant state.
  - Both heads valid: grant the source not equal to last_grant, then update last_grant.
  - One head valid: grant it; last_grant is still updated.
  - No head valid: no grant; last_grant is held.
- Grant effects: the granted entry is popped. The output register loads wsel, wdata and wen = mask.
- No grant: wen is loaded with all zeros. wsel and wdata hold their previous values.
- Register 0: an entry with wsel == 0 is still granted and popped, but wen is forced to zero. pending bit 0 is constantly 0.
- An entry with an all-zero mask is granted and popped normally, with wen = 0. It still contributes to pending while queued.
- pending is combinational: the OR of one-hot(wsel) over all valid FIFO entries and the output register (when wen != 0), excluding register 0.
- The arbiter has no ordering guarantee between sources. Same-register WAW ordering across sources is the issue stage's job, using pending.
- Reset (any time, including mid-transfer):
  - Both FIFOs emptied; queued entries are lost.
  - wen = 0, wsel = 0, wdata = 0.
  - last_grant = MEM, so the ALU wins the first contention.
  - alu_ready = mem_ready = 1 once RST is low.
  - pending = 0.

## Timing
- Push in cycle N → head visible and eligible in N+1 → wen asserted in N+2 → register file commits at the end of N+2 → readable from N+3.
- Minimum latency is 2 cycles. Sustained throughput is 1 write per cycle total.
- Each source alone sustains 1 push per cycle, since the pop frees its slot every cycle.
- Under continuous contention each source gets every other cycle. Its FIFO fills, and ready toggles low/high accordingly.
- FIFO pointers wrap modulo 2. The count saturates between 0 and 2.

## Structure
- Shared package cpu_types_pkg provides:
  - word_t.
  - regbits_t (5-bit register index).
  - A wb_entry_t struct {regbits_t wsel; logic [THREADS-1:0] mask; word_t wdata[THREADS]}. It is declared in this module because it depends on THREADS.
- Sub-module wb_fifo, a 2-deep FIFO with push, pop, full, empty, head and per-entry valid/wsel taps for pending. It is instantiated twice.
- A vector_wb_if interface bundle is optional. Ports as listed above are acceptable.

## Test plan
- Reset:
  - Assert RST mid-stream with both FIFOs holding 2 entries.
  - → wen = 0, pending = 0, both readies = 1 the cycle after RST deasserts.
  - → No stale write afterwards.
- Single ALU push:
  - ALU push wsel = 5, mask = 4'b1011, wdata = {1, 2, 3, 4} in cycle 0.
  - → wen = 4'b1011, wsel = 5 in cycle 2.
  - → pending[5] high in cycles 1-2 and low in cycle 3.
- Contention:
  - Both sources push every cycle for 8 cycles (ALU to wsel = 1, MEM to wsel = 2).
  - → First grant goes to ALU, then strict alternation.
  - → Each ready drops after its FIFO fills.
  - → No entry lost or duplicated; 16 writes total.
- Register 0:
  - MEM push wsel = 0, mask = 4'b1111.
  - → Entry consumed, wen stays 0, pending[0] stays 0.
- Full FIFO hold:
  - Hold the ALU FIFO full while MEM wins arbitration; the ALU keeps valid high.
  - → alu_ready low, alu_wsel changes ignored, queued ALU entries emitted unchanged and in order.
- Zero mask:
  - ALU push wsel = 7, mask = 0.
  - → pending[7] high while queued, wen = 0 when granted, the next entry follows with no bubble.
